// File: rtl/cbus_ram_responder_pkg.sv
// Shared cbus request/response types used by caches, bridges and memory models.
package common;

   typedef logic [7:0] strobe_t;

   typedef enum logic [3:0] {
      MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
      MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
      MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
      MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
   } mlen_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED    = 2'b00,
      AXI_BURST_INCR     = 2'b01,
      AXI_BURST_WRAP     = 2'b10,
      AXI_BURST_RESERVED = 2'b11
   } axi_burst_type_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic            valid;
      logic            is_write;
      msize_t          size;
      logic [31:0]     addr;
      strobe_t         strobe;
      logic [63:0]     data;
      mlen_t           len;
      axi_burst_type_t burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_ram_responder_ram.sv
// Single-port RAM with per-byte write enables; READ_LATENCY selects a combinational
// (0) or registered (1) read port. Contents are never reset.
module RAM_SinglePort #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 64,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 0
) (
   input  logic                             clk,
   input  logic                             en,
   input  logic [ADDR_WIDTH-1:0]            addr,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
   input  logic [DATA_WIDTH-1:0]            wdata,
   output logic [DATA_WIDTH-1:0]            rdata
);

   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (strobe[i])
               mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_comb_read
         always_comb rdata = mem[addr];
      end else begin : g_reg_read
         always_ff @(posedge clk) rdata <= mem[addr];
      end
   endgenerate

endmodule

// File: rtl/cbus_ram_responder.sv
// Memory-side cbus responder: accepts one burst at a time, waits LATENCY cycles,
// then returns one ready beat per cycle from (or into) a single-port RAM.
module cbus_ram_responder
   import common::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);

   typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;
   typedef logic [ADDR_WIDTH-1:0] waddr_t;

   localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t          state;
   logic [3:0]      wait_cnt;
   logic [3:0]      beat_cnt;
   waddr_t          addr_q;
   logic [3:0]      len_q;
   axi_burst_type_t burst_q;
   logic            wr_q;
   logic            ready_q;
   logic            last_q;

   logic            mem_we;
   logic [63:0]     rdata;
   logic            unused_req_bits;

   // WRAP only wraps for power-of-two beat counts 2..16; anything else advances like INCR.
   function automatic waddr_t next_addr(input waddr_t a, input axi_burst_type_t b,
                                        input logic [3:0] len);
      waddr_t mask;
      logic   wrap_ok;
      mask    = waddr_t'(len);
      wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      case (b)
         AXI_BURST_FIXED: next_addr = a;
         AXI_BURST_WRAP:  next_addr = wrap_ok ? ((a & ~mask) | ((a + 1'b1) & mask))
                                              : a + 1'b1;
         default:         next_addr = a + 1'b1;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         beat_cnt <= '0;
         ready_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (creq.valid) begin
                  addr_q   <= creq.addr[ADDR_WIDTH+2:3];
                  len_q    <= creq.len;
                  burst_q  <= creq.burst;
                  wr_q     <= creq.is_write;
                  beat_cnt <= '0;
                  wait_cnt <= WAIT_INIT;
                  if (LATENCY == 0) begin
                     state   <= ACTIVE;
                     ready_q <= 1'b1;
                     last_q  <= (creq.len == MLEN1);
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!creq.valid) begin
                  state <= IDLE;
               end else if (wait_cnt == 4'd0) begin
                  state   <= ACTIVE;
                  ready_q <= 1'b1;
                  last_q  <= (len_q == 4'd0);
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ACTIVE: begin
               if (!creq.valid || last_q) begin
                  state    <= IDLE;
                  ready_q  <= 1'b0;
                  last_q   <= 1'b0;
                  beat_cnt <= '0;
               end else begin
                  beat_cnt <= beat_cnt + 4'd1;
                  last_q   <= ((beat_cnt + 4'd1) == len_q);
                  addr_q   <= next_addr(addr_q, burst_q, len_q);
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   // An aborted beat (valid dropped) or a reset edge must not commit its write.
   assign mem_we = (state == ACTIVE) && wr_q && creq.valid && !reset;

   RAM_SinglePort #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (64),
      .BYTE_WIDTH  (8),
      .READ_LATENCY(0)
   ) u_ram (
      .clk   (clk),
      .en    (mem_we),
      .addr  (addr_q),
      .strobe(creq.strobe),
      .wdata (creq.data),
      .rdata (rdata)
   );

   always_comb begin
      cresp       = '0;
      cresp.ready = ready_q;
      cresp.last  = last_q;
      cresp.data  = ready_q ? rdata : '0;
   end

   assign unused_req_bits = ^{creq.size, creq.addr[31:ADDR_WIDTH+3], creq.addr[2:0]};

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Scoreboard bench for cbus_ram_responder: one instance with LATENCY=0, one with LATENCY=3.
`timescale 1ns/1ps
module tb_cbus_ram_responder;
   import common::*;

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  creq0, creq1;
   cbus_resp_t cresp0, cresp1;

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;

   logic [63:0] exp_q[$];
   logic [63:0] obs_data[$];
   bit          obs_last[$];
   int unsigned obs_cyc[$];
   int unsigned start_cyc;
   bit          timed_out;
   bit          ready_after;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cbus_ram_responder #(.ADDR_WIDTH(12), .LATENCY(0)) dut (
      .clk(clk), .reset(reset), .creq(creq0), .cresp(cresp0));

   cbus_ram_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut_lat (
      .clk(clk), .reset(reset), .creq(creq1), .cresp(cresp1));

   task automatic drive_req(input bit sel, input cbus_req_t r);
      if (sel) creq1 = r;
      else     creq0 = r;
   endtask

   function automatic cbus_resp_t get_resp(input bit sel);
      return sel ? cresp1 : cresp0;
   endfunction

   // Drives one burst and records every ready beat; rst_at>0 pulses reset on that beat's edge.
   task automatic do_burst(input bit sel, input bit wr, input logic [31:0] addr, input mlen_t len,
                           input axi_burst_type_t burst, input logic [63:0] dbase,
                           input strobe_t strb, input int rst_at);
      cbus_req_t  r;
      cbus_resp_t rs;
      int         beat = 0;
      int         guard = 0;
      obs_data.delete(); obs_last.delete(); obs_cyc.delete();
      timed_out = 0;
      r = '0;
      r.valid = 1'b1; r.is_write = wr; r.size = MSIZE8; r.addr = addr;
      r.strobe = strb; r.data = dbase; r.len = len; r.burst = burst;
      @(posedge clk); #1;
      drive_req(sel, r);
      start_cyc = cyc;
      forever begin
         @(negedge clk);
         rs = get_resp(sel);
         if (rs.ready) begin
            obs_data.push_back(rs.data);
            obs_last.push_back(rs.last);
            obs_cyc.push_back(cyc);
            beat++;
            if (beat == rst_at) begin
               reset = 1'b1;
               @(posedge clk); #1;
               reset = 1'b0;
               r.valid = 1'b0;
               drive_req(sel, r);
               break;
            end
            if (rs.last) begin
               @(posedge clk); #1;
               r.valid = 1'b0;
               drive_req(sel, r);
               break;
            end
         end
         guard++;
         if (guard > 64) begin
            timed_out = 1;
            @(posedge clk); #1;
            r.valid = 1'b0;
            drive_req(sel, r);
            break;
         end
         @(posedge clk); #1;
         r.data = dbase + 64'(beat);
         drive_req(sel, r);
      end
      @(negedge clk);
      rs = get_resp(sel);
      ready_after = rs.ready;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      creq0 = '0; creq1 = '0;
      creq0.valid = 1'b1; creq1.valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (cresp0 !== '0) begin
         fails++;
         $display("FAIL reset_resp0: got %h want 0", cresp0);
      end
      tests++;
      if (cresp1 !== '0) begin
         fails++;
         $display("FAIL reset_resp1: got %h want 0", cresp1);
      end
      @(posedge clk); #1;
      creq0 = '0; creq1 = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (cresp0.ready !== 1'b0 || cresp0.last !== 1'b0 || cresp0.data !== 64'h0) begin
         fails++;
         $display("FAIL idle_resp0: got r=%b l=%b d=%h want 0/0/0", cresp0.ready, cresp0.last, cresp0.data);
      end
      tests++;
      if (cresp1.ready !== 1'b0 || cresp1.last !== 1'b0 || cresp1.data !== 64'h0) begin
         fails++;
         $display("FAIL idle_resp1: got r=%b l=%b d=%h want 0/0/0", cresp1.ready, cresp1.last, cresp1.data);
      end
   endtask

   task automatic test_read_incr16();
      logic [63:0] e;
      do_burst(0, 1, 32'h80, MLEN16, AXI_BURST_INCR, 64'h0, 8'hFF, 0);
      for (int i = 0; i < 16; i++) exp_q.push_back(64'(i));
      do_burst(0, 0, 32'h80, MLEN16, AXI_BURST_INCR, 64'h0, 8'hFF, 0);
      tests++;
      if (timed_out || obs_data.size() != 16) begin
         fails++;
         $display("FAIL rd16_beats: got %0d beats want 16", obs_data.size());
      end
      tests++;
      if (obs_cyc.size() > 0 && obs_cyc[0] != start_cyc + 1) begin
         fails++;
         $display("FAIL rd16_first: got cycle %0d want %0d", obs_cyc[0], start_cyc + 1);
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = exp_q.size() ? exp_q.pop_front() : 64'hDEAD;
         tests++;
         if (obs_data[i] !== e || obs_last[i] !== (i == 15) || obs_cyc[i] != obs_cyc[0] + i) begin
            fails++;
            $display("FAIL rd16_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=%0d", i,
                     obs_data[i], obs_last[i], obs_cyc[i], e, (i == 15), obs_cyc[0] + i);
         end
      end
      tests++;
      if (ready_after !== 1'b0) begin
         fails++;
         $display("FAIL rd16_after: got ready=%b want 0", ready_after);
      end
      exp_q.delete();
   endtask

   task automatic test_write_incr16();
      logic [63:0] e;
      do_burst(0, 1, 32'h400, MLEN16, AXI_BURST_INCR, 64'hA0, 8'hFF, 0);
      for (int i = 0; i < 16; i++) exp_q.push_back(64'hA0 + 64'(i));
      do_burst(0, 0, 32'h400, MLEN16, AXI_BURST_INCR, 64'h0, 8'hFF, 0);
      tests++;
      if (timed_out || obs_data.size() != 16) begin
         fails++;
         $display("FAIL wr16_beats: got %0d beats want 16", obs_data.size());
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = exp_q.size() ? exp_q.pop_front() : 64'hDEAD;
         tests++;
         if (obs_data[i] !== e) begin
            fails++;
            $display("FAIL wr16_beat%0d: got %h want %h", i, obs_data[i], e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_write_fixed_strobe();
      do_burst(0, 1, 32'h1004, MLEN1, AXI_BURST_FIXED, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0);
      do_burst(0, 1, 32'h1004, MLEN1, AXI_BURST_FIXED, 64'h11223344_55667788, 8'h0F, 0);
      exp_q.push_back(64'hFFFFFFFF_55667788);
      do_burst(0, 0, 32'h1004, MLEN1, AXI_BURST_FIXED, 64'h0, 8'h00, 0);
      tests++;
      if (timed_out || obs_data.size() != 1) begin
         fails++;
         $display("FAIL strobe_beats: got %0d beats want 1", obs_data.size());
      end else begin
         tests++;
         if (obs_data[0] !== exp_q[0] || obs_last[0] !== 1'b1) begin
            fails++;
            $display("FAIL strobe_data: got d=%h l=%b want d=%h l=1", obs_data[0], obs_last[0], exp_q[0]);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_latency();
      logic [63:0] e;
      do_burst(1, 1, 32'h0, MLEN4, AXI_BURST_INCR, 64'h70, 8'hFF, 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(64'h70 + 64'(i));
      do_burst(1, 0, 32'h0, MLEN4, AXI_BURST_INCR, 64'h0, 8'hFF, 0);
      tests++;
      if (timed_out || obs_data.size() != 4) begin
         fails++;
         $display("FAIL lat_beats: got %0d beats want 4", obs_data.size());
      end
      tests++;
      if (obs_cyc.size() > 0 && obs_cyc[0] != start_cyc + 4) begin
         fails++;
         $display("FAIL lat_first: got cycle %0d want %0d", obs_cyc[0], start_cyc + 4);
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = exp_q.size() ? exp_q.pop_front() : 64'hDEAD;
         tests++;
         if (obs_data[i] !== e || obs_last[i] !== (i == 3) || obs_cyc[i] != start_cyc + 4 + i) begin
            fails++;
            $display("FAIL lat_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=%0d", i,
                     obs_data[i], obs_last[i], obs_cyc[i], e, (i == 3), start_cyc + 4 + i);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midburst();
      logic [63:0] e;
      do_burst(0, 1, 32'h800, MLEN16, AXI_BURST_INCR, 64'h3000, 8'hFF, 0);
      do_burst(0, 1, 32'h800, MLEN16, AXI_BURST_INCR, 64'h4000, 8'hFF, 6);
      tests++;
      if (obs_data.size() != 6 || ready_after !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid: got beats=%0d ready=%b want 6/0", obs_data.size(), ready_after);
      end
      for (int i = 0; i < 16; i++)
         exp_q.push_back(i < 5 ? 64'h4000 + 64'(i) : 64'h3000 + 64'(i));
      do_burst(0, 0, 32'h800, MLEN16, AXI_BURST_INCR, 64'h0, 8'hFF, 0);
      tests++;
      if (timed_out || obs_data.size() != 16) begin
         fails++;
         $display("FAIL rst_read_beats: got %0d beats want 16", obs_data.size());
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = exp_q.size() ? exp_q.pop_front() : 64'hDEAD;
         tests++;
         if (obs_data[i] !== e) begin
            fails++;
            $display("FAIL rst_word%0d: got %h want %h", i, obs_data[i], e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_wrap();
      logic [63:0] e;
      do_burst(0, 1, 32'h0, MLEN4, AXI_BURST_INCR, 64'h50, 8'hFF, 0);
      exp_q.push_back(64'h53); exp_q.push_back(64'h50);
      exp_q.push_back(64'h51); exp_q.push_back(64'h52);
      do_burst(0, 0, 32'h18, MLEN4, AXI_BURST_WRAP, 64'h0, 8'hFF, 0);
      tests++;
      if (timed_out || obs_data.size() != 4) begin
         fails++;
         $display("FAIL wrap4_beats: got %0d beats want 4", obs_data.size());
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = exp_q.size() ? exp_q.pop_front() : 64'hDEAD;
         tests++;
         if (obs_data[i] !== e || obs_last[i] !== (i == 3)) begin
            fails++;
            $display("FAIL wrap4_beat%0d: got d=%h l=%b want d=%h l=%b", i,
                     obs_data[i], obs_last[i], e, (i == 3));
         end
      end
      exp_q.delete();
      // Three beats is not a legal wrap size, so the burst runs linearly from word 1.
      exp_q.push_back(64'h51); exp_q.push_back(64'h52); exp_q.push_back(64'h53);
      do_burst(0, 0, 32'h08, MLEN3, AXI_BURST_WRAP, 64'h0, 8'hFF, 0);
      tests++;
      if (timed_out || obs_data.size() != 3) begin
         fails++;
         $display("FAIL wrap3_beats: got %0d beats want 3", obs_data.size());
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = exp_q.size() ? exp_q.pop_front() : 64'hDEAD;
         tests++;
         if (obs_data[i] !== e) begin
            fails++;
            $display("FAIL wrap3_beat%0d: got %h want %h", i, obs_data[i], e);
         end
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_read_incr16();
      test_write_incr16();
      test_write_fixed_strobe();
      test_latency();
      test_reset_midburst();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
